// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
//   Shared definitions for the PE accumulator slice.
//   - clog2      : ceiling log2, used to size the term counter
//   - pe_state_e : accumulator FSM encoding (S_IDLE, S_ACCUM, S_HOLD)
// ---------------------------------------------------------------------------
package pe_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } pe_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pe_accumulator_if.sv
// ---------------------------------------------------------------------------
// pe_acc_if
//   Product-in / result-out bundle of the PE accumulator.
//   master : upstream multiplier + result consumer (drives beats and out_ready)
//   slave  : the accumulator
//   in_valid/in_data/in_last : one product beat, in_last closes the dot-product
//   out_valid/out_ready      : one-entry result handshake
//   out_data/out_sat/out_err : narrowed result, saturation flag, forced-close flag
// ---------------------------------------------------------------------------
interface pe_acc_if #(
  parameter int BITWIDTH = 8
) ();

  logic                in_valid;
  logic [BITWIDTH-1:0] in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_data;
  logic                out_sat;
  logic                out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  out_valid, out_data, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output out_valid, out_data, out_sat, out_err
  );

endinterface

// File: rtl/pe_sat_add.sv
// ---------------------------------------------------------------------------
// pe_sat_add
//   Combinational unsigned add of an ACC_WIDTH operand and a BITWIDTH operand,
//   clamped to 2^ACC_WIDTH-1.
//   i_a   : accumulator value
//   i_b   : product to add (zero-extended)
//   o_sum : clamped sum
//   o_sat : 1 when the true sum did not fit and was clamped
// ---------------------------------------------------------------------------
module pe_sat_add #(
  parameter int ACC_WIDTH = 16,
  parameter int BITWIDTH  = 8
) (
  input  logic [ACC_WIDTH-1:0] i_a,
  input  logic [BITWIDTH-1:0]  i_b,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_sat
);

  logic [ACC_WIDTH:0] w_full;

  // One extra bit catches the carry; a set carry means the sum overflowed.
  always_comb begin
    w_full = {1'b0, i_a} + (ACC_WIDTH + 1)'(i_b);
    if (w_full[ACC_WIDTH]) begin
      o_sum = {ACC_WIDTH{1'b1}};
      o_sat = 1'b1;
    end else begin
      o_sum = w_full[ACC_WIDTH-1:0];
      o_sat = 1'b0;
    end
  end

endmodule

// File: rtl/pe_accumulator.sv
// ---------------------------------------------------------------------------
// pe_accumulator
//   Sums the products of one dot-product (closed by in_last or by reaching
//   MAX_TERMS terms) and presents the shifted, saturated result in a
//   one-entry valid/ready output register. Upstream cannot be stalled, so
//   beats arriving while a result is held are dropped and flagged in ovr.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous clear of ovr; aborts a dot-product in progress,
//          keeps any held result
//   bus  : pe_acc_if slave (product beats in, result handshake out)
//   ovr  : sticky dropped-beat flag
// ---------------------------------------------------------------------------
module pe_accumulator
  import pe_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SHIFT     = 0,
  parameter int MAX_TERMS = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  pe_acc_if.slave  bus,
  output logic     ovr
);

  localparam int CNT_W = clog2(MAX_TERMS) + 1;
  localparam logic [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'({BITWIDTH{1'b1}});

  pe_state_e             r_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  r_acc_sat;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_out_valid;
  logic [BITWIDTH-1:0]   r_out_data;
  logic                  r_out_sat;
  logic                  r_out_err;
  logic                  r_ovr;

  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_add_sat;
  logic [ACC_WIDTH-1:0]  w_beat_acc;
  logic                  w_beat_sat;
  logic [CNT_W-1:0]      w_beat_cnt;
  logic                  w_close;
  logic [ACC_WIDTH-1:0]  w_shifted;
  logic                  w_narrow_ovf;
  logic [BITWIDTH-1:0]   w_out_data;

  pe_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .BITWIDTH  (BITWIDTH)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (bus.in_data),
    .o_sum (w_sum),
    .o_sat (w_add_sat)
  );

  // Post-beat accumulator view: the first term loads, later terms add with clamp.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_beat_acc = ACC_WIDTH'(bus.in_data);
      w_beat_sat = 1'b0;
      w_beat_cnt = CNT_W'(1);
    end else begin
      w_beat_acc = w_sum;
      w_beat_sat = r_acc_sat | w_add_sat;
      w_beat_cnt = r_cnt + CNT_W'(1);
    end
    w_close = bus.in_last | (w_beat_cnt == CNT_W'(MAX_TERMS));
  end

  // Narrow the shifted accumulator to the output width, saturating on overflow.
  always_comb begin
    w_shifted    = w_beat_acc >> SHIFT;
    w_narrow_ovf = (w_shifted > OUT_MAX);
    if (w_narrow_ovf) begin
      w_out_data = {BITWIDTH{1'b1}};
    end else begin
      w_out_data = w_shifted[BITWIDTH-1:0];
    end
  end

  // Accumulator FSM with the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= {ACC_WIDTH{1'b0}};
      r_acc_sat   <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= {BITWIDTH{1'b0}};
      r_out_sat   <= 1'b0;
      r_out_err   <= 1'b0;
      r_ovr       <= 1'b0;
    end else if (clr) begin
      // A held result survives clr, so the FSM stays in HOLD until it is taken.
      r_state   <= r_out_valid ? S_HOLD : S_IDLE;
      r_acc     <= {ACC_WIDTH{1'b0}};
      r_acc_sat <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
      r_ovr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (bus.in_valid) begin
            r_acc     <= w_beat_acc;
            r_acc_sat <= w_beat_sat;
            r_cnt     <= w_beat_cnt;
            if (w_close) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_out_data;
              r_out_sat   <= w_beat_sat | w_narrow_ovf;
              // Closing without in_last can only be the MAX_TERMS limit.
              r_out_err   <= ~bus.in_last;
              r_state     <= S_HOLD;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (bus.in_valid) begin
            r_ovr <= 1'b1;
          end
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_err   = r_out_err;
  assign ovr           = r_ovr;

endmodule

// File: tb/tb_pe_accumulator.sv
// ---------------------------------------------------------------------------
// tb_pe_accumulator
//   Three accumulators share one stimulus stream: the default configuration,
//   one with SHIFT=2 and one with ACC_WIDTH=9. A reference model computes
//   each dot-product from its list of terms with plain integer arithmetic and
//   is compared against every instance on every cycle; literal expectations
//   at key points pin the model.
// ---------------------------------------------------------------------------
module tb_pe_accumulator;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
  logic       ovr_q[3];

  int n_cmp;
  int n_fail;

  pe_acc_if #(.BITWIDTH(8)) if_a ();
  pe_acc_if #(.BITWIDTH(8)) if_b ();
  pe_acc_if #(.BITWIDTH(8)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.in_data = in_data;
  assign if_a.in_last  = in_last;   assign if_a.out_ready = out_ready;
  assign if_b.in_valid = in_valid;  assign if_b.in_data = in_data;
  assign if_b.in_last  = in_last;   assign if_b.out_ready = out_ready;
  assign if_c.in_valid = in_valid;  assign if_c.in_data = in_data;
  assign if_c.in_last  = in_last;   assign if_c.out_ready = out_ready;

  pe_accumulator #(.BITWIDTH(8), .ACC_WIDTH(16), .SHIFT(0), .MAX_TERMS(16)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .bus(if_a), .ovr(ovr_q[0]));
  pe_accumulator #(.BITWIDTH(8), .ACC_WIDTH(16), .SHIFT(2), .MAX_TERMS(16)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .bus(if_b), .ovr(ovr_q[1]));
  pe_accumulator #(.BITWIDTH(8), .ACC_WIDTH(9), .SHIFT(0), .MAX_TERMS(16)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .bus(if_c), .ovr(ovr_q[2]));

  // Gathered DUT outputs, indexed like the model.
  logic       a_valid[3];
  logic [7:0] a_data[3];
  logic       a_sat[3];
  logic       a_err[3];
  assign a_valid[0] = if_a.out_valid; assign a_data[0] = if_a.out_data;
  assign a_sat[0]   = if_a.out_sat;   assign a_err[0]  = if_a.out_err;
  assign a_valid[1] = if_b.out_valid; assign a_data[1] = if_b.out_data;
  assign a_sat[1]   = if_b.out_sat;   assign a_err[1]  = if_b.out_err;
  assign a_valid[2] = if_c.out_valid; assign a_data[2] = if_c.out_data;
  assign a_sat[2]   = if_c.out_sat;   assign a_err[2]  = if_c.out_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int     sh_amt[3] = '{0, 2, 0};
  longint acc_max[3] = '{65535, 65535, 511};
  localparam int MAXT = 16;

  bit     m_open[3];
  longint m_sum[3];
  int     m_n[3];
  bit     e_valid[3];
  int     e_data[3];
  bit     e_sat[3];
  bit     e_err[3];
  bit     e_ovr[3];

  task automatic model_close(input int i, input bit forced);
    longint acc;
    longint shv;
    acc = (m_sum[i] > acc_max[i]) ? acc_max[i] : m_sum[i];
    shv = acc >>> sh_amt[i];
    e_valid[i] = 1'b1;
    e_data[i]  = (shv > 255) ? 255 : int'(shv);
    e_sat[i]   = (m_sum[i] > acc_max[i]) || (shv > 255);
    e_err[i]   = forced;
    m_open[i]  = 1'b0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_open[i] = 0; m_sum[i] = 0; m_n[i] = 0;
        e_valid[i] = 0; e_data[i] = 0; e_sat[i] = 0; e_err[i] = 0; e_ovr[i] = 0;
      end else if (clr) begin
        m_open[i] = 0; m_sum[i] = 0; m_n[i] = 0; e_ovr[i] = 0;
      end else if (e_valid[i]) begin
        if (in_valid) e_ovr[i] = 1'b1;
        if (out_ready) e_valid[i] = 1'b0;
      end else if (in_valid) begin
        if (!m_open[i]) begin
          m_sum[i] = in_data; m_n[i] = 1; m_open[i] = 1'b1;
        end else begin
          m_sum[i] += in_data; m_n[i]++;
        end
        if (in_last || m_n[i] == MAXT) model_close(i, !in_last);
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (a_valid[i] !== e_valid[i] || a_data[i] !== 8'(e_data[i]) || a_sat[i] !== e_sat[i] ||
          a_err[i] !== e_err[i] || ovr_q[i] !== e_ovr[i]) begin
        n_fail++;
        $display("FAIL model_dut%0d t=%0t: got v=%0b d=%0d s=%0b e=%0b o=%0b expected v=%0b d=%0d s=%0b e=%0b o=%0b",
                 i, $time, a_valid[i], a_data[i], a_sat[i], a_err[i], ovr_q[i],
                 e_valid[i], e_data[i], e_sat[i], e_err[i], e_ovr[i]);
      end
    end
  endtask

  // Model advances on each rising edge; DUT is checked just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns at the next falling edge.
  task automatic cyc(input bit v, input int d, input bit l, input bit rdy);
    in_valid  = v;
    in_data   = 8'(d);
    in_last   = l;
    out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; clr = 1'b0;
    in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", int'(if_a.out_valid), 0);
    chk("reset_data", int'(if_a.out_data), 0);
    rst = 1'b0;

    // 1: 16+20+70
    cyc(1, 16, 0, 1); cyc(1, 20, 0, 1);
    chk("t1_not_yet_valid", int'(if_a.out_valid), 0);
    cyc(1, 70, 1, 1);
    chk("t1_valid", int'(if_a.out_valid), 1);
    chk("t1_data", int'(if_a.out_data), 106);
    chk("t1_sat", int'(if_a.out_sat), 0);
    chk("t1_data_shift2", int'(if_b.out_data), 26);
    cyc(0, 0, 0, 1);
    chk("t1_handshake", int'(if_a.out_valid), 0);

    // 2: 200+100 saturates narrowing; shift 2 fits
    cyc(1, 200, 0, 1); cyc(1, 100, 1, 1);
    chk("t2_data", int'(if_a.out_data), 255);
    chk("t2_sat", int'(if_a.out_sat), 1);
    chk("t2_data_shift2", int'(if_b.out_data), 75);
    chk("t2_sat_shift2", int'(if_b.out_sat), 0);
    cyc(0, 0, 0, 1);

    // 3: sixteen 1s, forced close on the 16th
    for (int k = 0; k < 15; k++) cyc(1, 1, 0, 1);
    chk("t3_open_after_15", int'(if_a.out_valid), 0);
    cyc(1, 1, 0, 1);
    chk("t3_valid", int'(if_a.out_valid), 1);
    chk("t3_data", int'(if_a.out_data), 16);
    chk("t3_err", int'(if_a.out_err), 1);
    cyc(0, 0, 0, 1);

    // 4: hold with backpressure, dropped beat, then clr
    cyc(1, 10, 0, 0); cyc(1, 20, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc((k == 2), 9, 0, 0);
      chk("t4_hold_valid", int'(if_a.out_valid), 1);
      chk("t4_hold_data", int'(if_a.out_data), 30);
    end
    chk("t4_ovr", int'(ovr_q[0]), 1);
    cyc(0, 0, 0, 1);
    chk("t4_released", int'(if_a.out_valid), 0);
    cyc(1, 3, 1, 1);
    chk("t4_next_data", int'(if_a.out_data), 3);
    chk("t4_ovr_sticky", int'(ovr_q[0]), 1);
    cyc(0, 0, 0, 1);
    clr = 1'b1; cyc(0, 0, 0, 1); clr = 1'b0;
    chk("t4_ovr_cleared", int'(ovr_q[0]), 0);

    // 5: 3 x 255; ACC_WIDTH=9 clamps at 511
    cyc(1, 255, 0, 1); cyc(1, 255, 0, 1); cyc(1, 255, 1, 1);
    chk("t5_c_data", int'(if_c.out_data), 255);
    chk("t5_c_sat", int'(if_c.out_sat), 1);
    chk("t5_b_data", int'(if_b.out_data), 191);
    cyc(0, 0, 0, 1);

    // clr mid dot-product aborts the partial sum
    cyc(1, 5, 0, 1); cyc(1, 5, 0, 1);
    clr = 1'b1; cyc(0, 0, 0, 1); clr = 1'b0;
    cyc(1, 4, 1, 1);
    chk("clr_abort_data", int'(if_a.out_data), 4);
    cyc(0, 0, 0, 1);

    // 6: rst after 2 beats of a 4-term product
    cyc(1, 40, 0, 1); cyc(1, 50, 0, 1);
    rst = 1'b1; cyc(0, 0, 0, 1); rst = 1'b0;
    chk("t6_rst_valid", int'(if_a.out_valid), 0);
    chk("t6_rst_data", int'(if_a.out_data), 0);
    cyc(1, 7, 1, 1);
    chk("t6_data", int'(if_a.out_data), 7);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
